// File: rtl/cache_backing_memory.sv
// rtl/cache_backing_memory.sv - multi-cycle single-word main-memory model behind the cache
// Requests are captured, held for LAT clocks, then completed with a one-cycle m_ready strobe.
module cache_backing_memory #(
  parameter int    AW        = 10,
  parameter int    LAT       = 4,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] m_a,
  input  logic [31:0] m_d_w,
  input  logic        m_access,
  input  logic        m_write,
  output logic [31:0] m_d_r,
  output logic        m_ready,
  output logic        m_err,
  output logic [15:0] rd_cnt,
  output logic [15:0] wr_cnt,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] LAT_M1 = 8'(LAT - 1);

  state_t       state, next_state;
  logic [7:0]   cnt;
  logic [AW+1:0] a_q;
  logic [31:0]  d_q;
  logic         wr_q;
  logic [31:0]  mem [0:(1<<AW)-1];

  logic         capture;
  logic         fire;
  logic         mis_q;
  logic [AW-1:0] idx;
  logic         unused_addr_hi;

  // Upper address bits alias onto the array and carry no information.
  assign unused_addr_hi = ^m_a[31:AW+2];

  assign idx   = a_q[AW+1:2];
  assign mis_q = (a_q[1:0] != 2'b00);
  assign fire  = (state == BUSY) && (cnt == 8'd0);
  // DONE also accepts a request so a held m_access gets one access per LAT+1 clocks.
  assign capture = m_access && ((state == IDLE) || (state == DONE));

  assign m_ready = (state == DONE);
  assign busy    = (state != IDLE);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (m_access) next_state = BUSY;
      BUSY:    if (cnt == 8'd0) next_state = DONE;
      DONE:    next_state = m_access ? BUSY : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state  <= IDLE;
      cnt    <= 8'd0;
      a_q    <= '0;
      d_q    <= 32'd0;
      wr_q   <= 1'b0;
      m_d_r  <= 32'd0;
      m_err  <= 1'b0;
      rd_cnt <= 16'd0;
      wr_cnt <= 16'd0;
    end else begin
      state <= next_state;
      if (capture) begin
        a_q  <= m_a[AW+1:0];
        d_q  <= m_d_w;
        wr_q <= m_write;
        cnt  <= LAT_M1;
        if (m_a[1:0] != 2'b00) m_err <= 1'b1;
      end else if ((state == BUSY) && (cnt != 8'd0)) begin
        cnt <= cnt - 8'd1;
      end
      if (fire) begin
        if (!wr_q) m_d_r <= mis_q ? 32'd0 : mem[idx];
        if (!mis_q) begin
          if (wr_q) wr_cnt <= wr_cnt + 16'd1;
          else      rd_cnt <= rd_cnt + 16'd1;
        end
      end
    end
  end

  // Array has no reset; the write is gated by the reset-cleared state so an aborted write never lands.
  always_ff @(posedge clk) begin
    if (fire && wr_q && !mis_q) mem[idx] <= d_q;
  end

endmodule
